fetch_unit: RTL

- Instruction fetch initiator: owns the program counter and drives the instruction memory's iAddr/FETCH interface.
- Waits out the memory's registered read latency, captures the returned byte into an instruction register, and presents it to the control unit under a valid/ack handshake.
- Also supports PC load (jump) from the control unit.
- Sits between the control unit and instruction memory in the downsampling processor.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: bus widths common with the
// instruction memory and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 8;
    localparam int unsigned FETCH_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Width of a down-counter that must hold MEM_LAT-1 (at least one bit).
    function automatic int unsigned wait_cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns the PC, strobes the instruction memory, waits
// out its read latency and hands the captured byte to the control unit.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned DATA_W   = FETCH_DATA_W,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              ack,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic [DATA_W-1:0] instr,
    output logic              FETCH,
    output logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    localparam int unsigned CNT_W = wait_cnt_width(MEM_LAT);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_iaddr;
    logic              r_fetch;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic w_start;
    logic w_jump;
    logic w_capture;
    logic w_consume;
    logic w_cnt_load;
    logic w_cnt_dec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_jump      = 1'b0;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                // A jump wins over a simultaneous request; the request is dropped.
                if (jmp) begin
                    w_jump = 1'b1;
                end else if (req) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_cnt_load  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (jmp) begin
                    w_jump      = 1'b1;
                    w_consume   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (ack) begin
                    w_consume = 1'b1;
                    if (req) begin
                        w_start     = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc       <= ADDR_W'(RESET_PC);
            r_iaddr    <= ADDR_W'(RESET_PC);
            r_fetch    <= 1'b0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_jump) begin
                r_pc <= jmp_addr;
            end else if (w_capture) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_start) begin
                r_iaddr <= r_pc;
            end

            // REQ always lasts one cycle, so the strobe simply follows entry into REQ.
            r_fetch <= w_start;

            if (w_cnt_load) begin
                r_cnt <= CNT_W'(MEM_LAT - 1);
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_ir <= instr;
            end

            if (w_capture) begin
                r_ir_valid <= 1'b1;
            end else if (w_consume) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign FETCH    = r_fetch;
    assign iAddr    = r_iaddr;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;
    assign busy     = (r_state == REQ) || (r_state == WAIT);

endmodule
